// File: rtl/tank_fire_ctrl.sv
// ----------------------------------------------------------------------------
// tank_fire_ctrl
//   Per-player fire controller placed directly upstream of the bullet manager.
//   It turns the fire button into a one-cycle shot request. Shots are gated by
//   a shot cooldown, a finite magazine with a timed reload, and the tank-alive
//   status. The block also holds the timed spread and pierce power-up states
//   that the bullet manager samples together with the shot request.
//
//   Optional feature: define TANK_FIRE_AUTOFIRE_EN to enable autofire. With it
//   defined, holding the button fires again as soon as the block is READY.
//   Without it, every shot needs a fresh rising edge of the button.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   game_tick     in   one-cycle pulse per game step
//   game_start    in   level; low holds the block in its reset state
//   tank_alive    in   level; high while the owning tank is alive
//   fire_btn      in   button level, already synchronised to clk
//   spread_grant  in   one-cycle pulse when a spread power-up is collected
//   pierce_grant  in   one-cycle pulse when a pierce power-up is collected
//   fire          out  registered one-cycle shot request
//   spread        out  registered; high while the spread timer is nonzero
//   pierce        out  registered; high while the pierce timer is nonzero
//   ammo          out  rounds remaining in the magazine
//   reloading     out  high while the state is RELOAD
//   spread_left   out  current spread timer value (HUD)
//   pierce_left   out  current pierce timer value (HUD)
// ----------------------------------------------------------------------------
module tank_fire_ctrl #(
    parameter int unsigned COOLDOWN_TICKS = 4,
    parameter int unsigned MAG_SIZE       = 5,
    parameter int unsigned RELOAD_TICKS   = 40,
    parameter int unsigned POWERUP_TICKS  = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic       game_start,
    input  logic       tank_alive,
    input  logic       fire_btn,
    input  logic       spread_grant,
    input  logic       pierce_grant,
    output logic       fire,
    output logic       spread,
    output logic       pierce,
    output logic [3:0] ammo,
    output logic       reloading,
    output logic [9:0] spread_left,
    output logic [9:0] pierce_left
);

    typedef enum logic [1:0] {
        ST_READY,
        ST_COOLDOWN,
        ST_RELOAD
    } state_t;

    localparam logic [7:0] LP_CD     = COOLDOWN_TICKS[7:0];
    localparam logic [7:0] LP_RELOAD = RELOAD_TICKS[7:0];
    localparam logic [3:0] LP_MAG    = MAG_SIZE[3:0];
    localparam logic [9:0] LP_PWR    = POWERUP_TICKS[9:0];

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cd;
    logic [7:0] w_cd_nxt;
    logic [3:0] r_ammo;
    logic [3:0] w_ammo_nxt;
    logic       r_btn_q;
    logic       r_fire;
    logic       r_spread;
    logic       r_pierce;
    logic [9:0] r_spread_t;
    logic [9:0] r_pierce_t;
    logic [9:0] w_spread_t_nxt;
    logic [9:0] w_pierce_t_nxt;
    logic       w_clr;
    logic       w_trig;
    logic       w_shoot;

    assign w_clr = rst | ~game_start;

`ifdef TANK_FIRE_AUTOFIRE_EN
    assign w_trig = fire_btn;
`else
    assign w_trig = fire_btn & ~r_btn_q;
`endif

    assign w_shoot = (r_state == ST_READY) & tank_alive & w_trig & (r_ammo != '0);

    // Death clears a timer outright. Otherwise a grant reloads the full value
    // (it wins over a coincident tick), and a tick counts a nonzero timer down.
    function automatic logic [9:0] f_timer_nxt(input logic [9:0] t,
                                               input logic       grant,
                                               input logic       alive,
                                               input logic       tick);
        logic [9:0] v;
        v = t;
        if (!alive)
            v = '0;
        else if (grant)
            v = LP_PWR;
        else if (tick && (t != '0))
            v = t - 10'd1;
        return v;
    endfunction

    assign w_spread_t_nxt = f_timer_nxt(r_spread_t, spread_grant, tank_alive, game_tick);
    assign w_pierce_t_nxt = f_timer_nxt(r_pierce_t, pierce_grant, tank_alive, game_tick);

    // State register, together with the counters and flags it owns.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state    <= ST_READY;
            r_cd       <= '0;
            r_ammo     <= LP_MAG;
            r_btn_q    <= 1'b0;
            r_fire     <= 1'b0;
            r_spread   <= 1'b0;
            r_pierce   <= 1'b0;
            r_spread_t <= '0;
            r_pierce_t <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cd       <= w_cd_nxt;
            r_ammo     <= w_ammo_nxt;
            r_btn_q    <= fire_btn;
            r_fire     <= w_shoot;
            // The flags are registered from the next timer values. This keeps
            // each flag exactly equal to (timer != 0), and on the fire cycle
            // the triple reflects what the press cycle decided.
            r_spread   <= (w_spread_t_nxt != '0);
            r_pierce   <= (w_pierce_t_nxt != '0);
            r_spread_t <= w_spread_t_nxt;
            r_pierce_t <= w_pierce_t_nxt;
        end
    end

    // Next-state logic. The state keeps counting while the tank is dead, so a
    // reload that is in progress still completes.
    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_cd;
        w_ammo_nxt  = r_ammo;
        if (w_shoot) begin
            // A tick that arrives together with the shot is swallowed by the load.
            w_ammo_nxt = r_ammo - 4'd1;
            if (r_ammo == 4'd1) begin
                w_state_nxt = ST_RELOAD;
                w_cd_nxt    = LP_RELOAD;
            end else begin
                w_state_nxt = ST_COOLDOWN;
                w_cd_nxt    = LP_CD;
            end
        end else if ((r_state != ST_READY) && game_tick) begin
            if (r_cd <= 8'd1) begin
                w_cd_nxt    = '0;
                w_state_nxt = ST_READY;
                if (r_state == ST_RELOAD)
                    w_ammo_nxt = LP_MAG;
            end else begin
                w_cd_nxt = r_cd - 8'd1;
            end
        end
    end

    // Output logic.
    always_comb begin
        fire        = r_fire;
        spread      = r_spread;
        pierce      = r_pierce;
        ammo        = r_ammo;
        reloading   = (r_state == ST_RELOAD);
        spread_left = r_spread_t;
        pierce_left = r_pierce_t;
    end

endmodule

// File: tb/tb_tank_fire_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tank_fire_ctrl
//   Directed bench for tank_fire_ctrl with its default parameters. A
//   rule-level model tracks magazine, wait ticks and power-up lifetimes as
//   plain integers. Every cycle, the DUT outputs are checked against that
//   model. Literal checks at key points pin both the model and the DUT.
// ----------------------------------------------------------------------------
module tb_tank_fire_ctrl;

    localparam int CD  = 4;
    localparam int MAG = 5;
    localparam int RLD = 40;
    localparam int PWR = 600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_tick = 1'b0;
    logic       game_start = 1'b1;
    logic       tank_alive = 1'b1;
    logic       fire_btn = 1'b0;
    logic       spread_grant = 1'b0;
    logic       pierce_grant = 1'b0;
    logic       fire;
    logic       spread;
    logic       pierce;
    logic [3:0] ammo;
    logic       reloading;
    logic [9:0] spread_left;
    logic [9:0] pierce_left;

    int n_vec  = 0;
    int n_miss = 0;

    tank_fire_ctrl #(
        .COOLDOWN_TICKS(CD),
        .MAG_SIZE      (MAG),
        .RELOAD_TICKS  (RLD),
        .POWERUP_TICKS (PWR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_tick   (game_tick),
        .game_start  (game_start),
        .tank_alive  (tank_alive),
        .fire_btn    (fire_btn),
        .spread_grant(spread_grant),
        .pierce_grant(pierce_grant),
        .fire        (fire),
        .spread      (spread),
        .pierce      (pierce),
        .ammo        (ammo),
        .reloading   (reloading),
        .spread_left (spread_left),
        .pierce_left (pierce_left)
    );

    always #5 clk = ~clk;

    // Rule-level model: mode 0 = may shoot, 1 = cooling, 2 = reloading.
    // m_wait is the number of game ticks still owed before shooting is allowed.
    int m_mode = 0;
    int m_wait = 0;
    int m_ammo = MAG;
    int m_sp   = 0;
    int m_pi   = 0;
    int m_fire = 0;
    int m_prev = 0;

    always @(posedge clk) begin
        int press;
        int shoot;
        if (rst || !game_start) begin
            m_mode = 0; m_wait = 0; m_ammo = MAG;
            m_sp = 0; m_pi = 0; m_fire = 0; m_prev = 0;
        end else begin
`ifdef TANK_FIRE_AUTOFIRE_EN
            press = int'(fire_btn);
`else
            press = (fire_btn && m_prev == 0) ? 1 : 0;
`endif
            shoot  = (m_mode == 0 && tank_alive && press == 1 && m_ammo > 0) ? 1 : 0;
            m_fire = shoot;
            if (shoot == 1) begin
                m_ammo = m_ammo - 1;
                m_mode = (m_ammo == 0) ? 2 : 1;
                m_wait = (m_ammo == 0) ? RLD : CD;
            end else if (m_mode != 0 && game_tick) begin
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    if (m_mode == 2) m_ammo = MAG;
                    m_mode = 0;
                end
            end
            if (!tank_alive)       m_sp = 0;
            else if (spread_grant) m_sp = PWR;
            else if (game_tick && m_sp > 0) m_sp = m_sp - 1;
            if (!tank_alive)       m_pi = 0;
            else if (pierce_grant) m_pi = PWR;
            else if (game_tick && m_pi > 0) m_pi = m_pi - 1;
            m_prev = int'(fire_btn);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    bit chk_en   = 1'b0;
    bit prev_f   = 1'b0;
    bit cnt_en   = 1'b0;
    int n_pulses = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fire",        int'(fire),        m_fire);
            chk("ammo",        int'(ammo),        m_ammo);
            chk("reloading",   int'(reloading),   (m_mode == 2) ? 1 : 0);
            chk("spread",      int'(spread),      (m_sp != 0) ? 1 : 0);
            chk("pierce",      int'(pierce),      (m_pi != 0) ? 1 : 0);
            chk("spread_left", int'(spread_left), m_sp);
            chk("pierce_left", int'(pierce_left), m_pi);
            chk("fire_not_back_to_back", int'(prev_f && fire), 0);
            prev_f = fire;
        end
        if (cnt_en && fire) n_pulses++;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_tick();
        game_tick = 1'b1;
        cyc();
        game_tick = 1'b0;
        cyc();
    endtask

    task automatic do_press(output int got);
        fire_btn = 1'b1;
        cyc();
        got = int'(fire);
        fire_btn = 1'b0;
        cyc();
    endtask

    initial begin
        int got;
        repeat (3) cyc();
        chk_en = 1'b1;
        chk("rst_ammo",      int'(ammo), 5);
        chk("rst_fire",      int'(fire), 0);
        chk("rst_reloading", int'(reloading), 0);
        chk("rst_spread",    int'(spread_left), 0);
        rst = 1'b0;
        repeat (6) cyc();

        // Single press: fire appears one cycle after the button rises and lasts one cycle.
        fire_btn = 1'b1;
        cyc();
        chk("fire_rise",      int'(fire), 1);
        chk("ammo_5_to_4",    int'(ammo), 4);
        chk("model_ammo_4",   m_ammo, 4);
        cyc();
        chk("hold_one_pulse", int'(fire), 0);
        fire_btn = 1'b0;
        cyc();

        // Cooldown: presses after 1 and 3 ticks are ignored; after the 4th tick a press fires.
        do_tick();
        do_press(got);
        chk("press_cd_1tick", got, 0);
        chk("ammo_stays_4",   int'(ammo), 4);
        repeat (2) do_tick();
        do_press(got);
        chk("press_cd_3tick", got, 0);
        do_tick();
        do_press(got);
        chk("press_after_cd", got, 1);
        chk("ammo_3",         int'(ammo), 3);

        // Empty the magazine, then check the reload.
        repeat (3) begin
            repeat (CD) do_tick();
            do_press(got);
            chk("spaced_shot", got, 1);
        end
        chk("ammo_empty",      int'(ammo), 0);
        chk("reloading_set",   int'(reloading), 1);
        do_press(got);
        chk("press_in_reload", got, 0);
        repeat (RLD - 1) do_tick();
        chk("reload_39",       int'(reloading), 1);
        chk("ammo_still_0",    int'(ammo), 0);
        do_tick();
        chk("reload_done",     int'(reloading), 0);
        chk("ammo_refill",     int'(ammo), 5);

        // Spread power-up lifetime.
        spread_grant = 1'b1;
        cyc();
        spread_grant = 1'b0;
        chk("spread_on",   int'(spread), 1);
        chk("spread_600",  int'(spread_left), 600);
        do_tick();
        chk("spread_599",  int'(spread_left), 599);
        spread_grant = 1'b1;
        game_tick    = 1'b1;
        cyc();
        spread_grant = 1'b0;
        game_tick    = 1'b0;
        chk("grant_beats_tick", int'(spread_left), 600);
        repeat (590) do_tick();
        chk("spread_10",   int'(spread_left), 10);
        chk("model_sp_10", m_sp, 10);
        spread_grant = 1'b1;
        cyc();
        spread_grant = 1'b0;
        chk("regrant_600", int'(spread_left), 600);
        repeat (599) do_tick();
        chk("spread_last", int'(spread), 1);
        chk("spread_1",    int'(spread_left), 1);
        do_tick();
        chk("spread_off",  int'(spread), 0);
        do_tick();
        chk("no_wrap",     int'(spread_left), 0);

        // Death in the middle of a cooldown with pierce active.
        pierce_grant = 1'b1;
        cyc();
        pierce_grant = 1'b0;
        chk("pierce_on", int'(pierce), 1);
        do_press(got);
        chk("shot_before_death", got, 1);
        tank_alive = 1'b0;
        cyc();
        chk("pierce_cleared", int'(pierce), 0);
        chk("pierce_left_0",  int'(pierce_left), 0);
        do_press(got);
        chk("dead_no_fire",   got, 0);
        pierce_grant = 1'b1;
        cyc();
        pierce_grant = 1'b0;
        chk("dead_no_grant",  int'(pierce), 0);
        repeat (CD) do_tick();
        tank_alive = 1'b1;
        do_press(got);
        chk("cd_ran_while_dead", got, 1);
        chk("ammo_after_revive", int'(ammo), 3);

        // Game restart while in the middle of operation.
        spread_grant = 1'b1;
        cyc();
        spread_grant = 1'b0;
        game_start = 1'b0;
        cyc();
        chk("restart_ammo",   int'(ammo), 5);
        chk("restart_fire",   int'(fire), 0);
        chk("restart_spread", int'(spread), 0);
        chk("restart_sleft",  int'(spread_left), 0);
        chk("restart_reload", int'(reloading), 0);
        game_start = 1'b1;
        cyc();

        // Held button: a single shot, or the full magazine when autofire is enabled.
        cnt_en   = 1'b1;
        fire_btn = 1'b1;
        repeat (50) do_tick();
        fire_btn = 1'b0;
        cyc();
        cnt_en = 1'b0;
`ifdef TANK_FIRE_AUTOFIRE_EN
        chk("held_pulses", n_pulses, 5);
`else
        chk("held_pulses", n_pulses, 1);
`endif
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
